// File: rtl/mem_arb_2p.sv
// mem_arb_2p
// Two-port arbiter in front of a single-port synchronous RAM (address and
// write are captured on the clock edge, read data arrives one cycle later).
// Port 0 is the CPU data side and port 1 is the UART loader/debug side.
// The arbiter grants at most one access per cycle and steers the returning
// read data to the port that issued the read. A port can hold i_lockN to
// keep ownership across a multi-cycle atomic sequence.
//
// Parameters:
//   AW        memory address width
//   DW        memory data width
//   FIXED_PRI 0 = round-robin on contention, 1 = port 0 always wins
//
// Ports:
//   i_clk, i_nrst             clock, asynchronous active-low reset
//   i_reqN, i_weN, i_lockN    port N request (held until granted), write, lock
//   i_addrN, i_wdataN         port N address and write data
//   o_gntN                    port N access accepted this cycle (combinational)
//   o_rvalidN, o_rdataN       port N read return, one cycle after the grant
//   o_mem_addr/we/wdata       towards the RAM
//   i_mem_rdata               from the RAM, valid one cycle after the address

module mem_arb_2p #(
  parameter int AW        = 10,
  parameter int DW        = 8,
  parameter int FIXED_PRI = 0
) (
  input  logic          i_clk,
  input  logic          i_nrst,
  input  logic          i_req0,
  input  logic          i_we0,
  input  logic          i_lock0,
  input  logic [AW-1:0] i_addr0,
  input  logic [DW-1:0] i_wdata0,
  output logic          o_gnt0,
  output logic          o_rvalid0,
  output logic [DW-1:0] o_rdata0,
  input  logic          i_req1,
  input  logic          i_we1,
  input  logic          i_lock1,
  input  logic [AW-1:0] i_addr1,
  input  logic [DW-1:0] i_wdata1,
  output logic          o_gnt1,
  output logic          o_rvalid1,
  output logic [DW-1:0] o_rdata1,
  output logic [AW-1:0] o_mem_addr,
  output logic          o_mem_we,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata
);

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   last_winner;
  logic   rd_valid;
  logic   rd_owner;

  // Lock ownership register.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state <= ST_ARB;
    end else begin
      state <= state_nxt;
    end
  end

  // A locked port keeps ownership until the first edge where it drops
  // either its lock or its request; that final cycle is still arbitrated
  // as locked, so the other port only gets in on the following cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_ARB: begin
        if (o_gnt0 && i_lock0) begin
          state_nxt = ST_LOCK0;
        end else if (o_gnt1 && i_lock1) begin
          state_nxt = ST_LOCK1;
        end
      end
      ST_LOCK0: begin
        if (!i_lock0 || !i_req0) begin
          state_nxt = ST_ARB;
        end
      end
      ST_LOCK1: begin
        if (!i_lock1 || !i_req1) begin
          state_nxt = ST_ARB;
        end
      end
      default: state_nxt = ST_ARB;
    endcase
  end

  // Grant selection. Grants are forced low during reset. On contention
  // in round-robin mode the port that did not win last time goes first;
  // last_winner resets to 1 so port 0 takes the very first tie.
  always_comb begin
    o_gnt0 = 1'b0;
    o_gnt1 = 1'b0;
    if (i_nrst) begin
      case (state)
        ST_ARB: begin
          if (i_req0 && i_req1) begin
            if (FIXED_PRI != 0 || last_winner) begin
              o_gnt0 = 1'b1;
            end else begin
              o_gnt1 = 1'b1;
            end
          end else begin
            o_gnt0 = i_req0;
            o_gnt1 = i_req1;
          end
        end
        ST_LOCK0: o_gnt0 = i_req0;
        ST_LOCK1: o_gnt1 = i_req1;
        default: begin
          o_gnt0 = 1'b0;
          o_gnt1 = 1'b0;
        end
      endcase
    end
  end

  // RAM-side mux. With no grant the bus parks on port 0 with writes off.
  always_comb begin
    o_mem_addr  = i_addr0;
    o_mem_we    = 1'b0;
    o_mem_wdata = i_wdata0;
    if (o_gnt1) begin
      o_mem_addr  = i_addr1;
      o_mem_we    = i_we1;
      o_mem_wdata = i_wdata1;
    end else if (o_gnt0) begin
      o_mem_we    = i_we0;
    end
  end

  // Round-robin history and read-return tracking. A granted read marks
  // the next cycle as a valid return for its port; rd_owner only moves on
  // a read grant so it always names the port whose data is on the bus.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      last_winner <= 1'b1;
      rd_valid    <= 1'b0;
      rd_owner    <= 1'b0;
    end else begin
      if (o_gnt0) begin
        last_winner <= 1'b0;
      end else if (o_gnt1) begin
        last_winner <= 1'b1;
      end
      rd_valid <= (o_gnt0 && !i_we0) || (o_gnt1 && !i_we1);
      if (o_gnt1 && !i_we1) begin
        rd_owner <= 1'b1;
      end else if (o_gnt0 && !i_we0) begin
        rd_owner <= 1'b0;
      end
    end
  end

  assign o_rvalid0 = rd_valid && !rd_owner;
  assign o_rvalid1 = rd_valid && rd_owner;
  assign o_rdata0  = i_mem_rdata;
  assign o_rdata1  = i_mem_rdata;

endmodule

// File: tb/tb_mem_arb_2p.sv
// tb_mem_arb_2p
// Bench for mem_arb_2p. Two instances share one set of port stimulus: a
// round-robin instance (rr_*) and a fixed-priority instance (fp_*), each
// with its own behavioural 1024x8 RAM. Expected read returns for the
// round-robin instance are queued when the grant is seen and retired by a
// monitor on the cycle the return is due.

module tb_mem_arb_2p;

  logic       clk;
  logic       nrst;
  logic       req0, we0, lock0, req1, we1, lock1;
  logic [9:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;

  logic       rr_gnt0, rr_gnt1, rr_rvalid0, rr_rvalid1, rr_mem_we;
  logic [7:0] rr_rdata0, rr_rdata1, rr_mem_wdata, rr_mem_rdata;
  logic [9:0] rr_mem_addr;
  logic       fp_gnt0, fp_gnt1, fp_rvalid0, fp_rvalid1, fp_mem_we;
  logic [7:0] fp_rdata0, fp_rdata1, fp_mem_wdata, fp_mem_rdata;
  logic [9:0] fp_mem_addr;

  logic [7:0] ram_rr [1024];
  logic [7:0] ram_fp [1024];
  logic [7:0] ref_mem [1024];

  typedef struct {
    int         due;
    bit         port;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   sb_en = 1'b1;

  mem_arb_2p #(.AW(10), .DW(8), .FIXED_PRI(0)) u_rr (
    .i_clk(clk), .i_nrst(nrst),
    .i_req0(req0), .i_we0(we0), .i_lock0(lock0), .i_addr0(addr0), .i_wdata0(wdata0),
    .o_gnt0(rr_gnt0), .o_rvalid0(rr_rvalid0), .o_rdata0(rr_rdata0),
    .i_req1(req1), .i_we1(we1), .i_lock1(lock1), .i_addr1(addr1), .i_wdata1(wdata1),
    .o_gnt1(rr_gnt1), .o_rvalid1(rr_rvalid1), .o_rdata1(rr_rdata1),
    .o_mem_addr(rr_mem_addr), .o_mem_we(rr_mem_we), .o_mem_wdata(rr_mem_wdata),
    .i_mem_rdata(rr_mem_rdata)
  );

  mem_arb_2p #(.AW(10), .DW(8), .FIXED_PRI(1)) u_fp (
    .i_clk(clk), .i_nrst(nrst),
    .i_req0(req0), .i_we0(we0), .i_lock0(lock0), .i_addr0(addr0), .i_wdata0(wdata0),
    .o_gnt0(fp_gnt0), .o_rvalid0(fp_rvalid0), .o_rdata0(fp_rdata0),
    .i_req1(req1), .i_we1(we1), .i_lock1(lock1), .i_addr1(addr1), .i_wdata1(wdata1),
    .o_gnt1(fp_gnt1), .o_rvalid1(fp_rvalid1), .o_rdata1(fp_rdata1),
    .o_mem_addr(fp_mem_addr), .o_mem_we(fp_mem_we), .o_mem_wdata(fp_mem_wdata),
    .i_mem_rdata(fp_mem_rdata)
  );

  // Initial RAM contents: a simple address pattern with 0x5A at 0x005.
  function automatic logic [7:0] init_val(input int i);
    if (i == 5) return 8'h5A;
    return 8'(i * 7 + 3);
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural synchronous RAMs, read-before-write.
  initial begin
    for (int i = 0; i < 1024; i++) ram_rr[i] <= init_val(i);
    forever begin
      @(posedge clk);
      if (rr_mem_we) ram_rr[rr_mem_addr] <= rr_mem_wdata;
      rr_mem_rdata <= ram_rr[rr_mem_addr];
    end
  end

  initial begin
    for (int i = 0; i < 1024; i++) ram_fp[i] <= init_val(i);
    forever begin
      @(posedge clk);
      if (fp_mem_we) ram_fp[fp_mem_addr] <= fp_mem_wdata;
      fp_mem_rdata <= ram_fp[fp_mem_addr];
    end
  end

  // Read-return monitor for the round-robin instance.
  always @(negedge clk) begin
    exp_t e;
    if (sb_en) begin
      n_checks++;
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        if (e.port == 1'b0) begin
          if (rr_rvalid0 !== 1'b1 || rr_rvalid1 !== 1'b0 || rr_rdata0 !== e.data) begin
            n_errors++;
            $display("[TB] FAIL rd_return0 cyc=%0d: rvalid0=%b rvalid1=%b rdata0=%h, expected 1 0 %h",
                     cyc, rr_rvalid0, rr_rvalid1, rr_rdata0, e.data);
          end
        end else begin
          if (rr_rvalid1 !== 1'b1 || rr_rvalid0 !== 1'b0 || rr_rdata1 !== e.data) begin
            n_errors++;
            $display("[TB] FAIL rd_return1 cyc=%0d: rvalid0=%b rvalid1=%b rdata1=%h, expected 0 1 %h",
                     cyc, rr_rvalid0, rr_rvalid1, rr_rdata1, e.data);
          end
        end
      end else begin
        if (rr_rvalid0 !== 1'b0 || rr_rvalid1 !== 1'b0) begin
          n_errors++;
          $display("[TB] FAIL rvalid_idle cyc=%0d: rvalid0=%b rvalid1=%b, expected 0 0",
                   cyc, rr_rvalid0, rr_rvalid1);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic drive(input logic r0, input logic w0, input logic l0,
                       input logic [9:0] a0, input logic [7:0] d0,
                       input logic r1, input logic w1, input logic l1,
                       input logic [9:0] a1, input logic [7:0] d1);
    req0 = r0; we0 = w0; lock0 = l0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; lock1 = l1; addr1 = a1; wdata1 = d1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Let any due return be checked, then pulse reset for two edges.
  task automatic do_reset();
    drive(0, 0, 0, 10'h000, 8'h00, 0, 0, 0, 10'h000, 8'h00);
    @(negedge clk);
    #1;
    nrst = 1'b0;
    sb.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    nrst = 1'b1;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    drive(1, 0, 0, 10'h001, 8'h00, 1, 0, 0, 10'h002, 8'h00);
    @(posedge clk);
    #2;
    n_checks++;
    if ({rr_gnt0, rr_gnt1, fp_gnt0, fp_gnt1} !== 4'b0000) begin
      n_errors++;
      $display("[TB] FAIL reset_gnt: rr=%b%b fp=%b%b, expected all 0", rr_gnt0, rr_gnt1, fp_gnt0, fp_gnt1);
    end
    n_checks++;
    if ({rr_rvalid0, rr_rvalid1, fp_rvalid0, fp_rvalid1, rr_mem_we} !== 5'b00000) begin
      n_errors++;
      $display("[TB] FAIL reset_rvalid: rr=%b%b fp=%b%b we=%b, expected all 0",
               rr_rvalid0, rr_rvalid1, fp_rvalid0, fp_rvalid1, rr_mem_we);
    end
    do_reset();
  endtask

  task automatic test_single_read();
    do_reset();
    drive(1, 0, 0, 10'h005, 8'h00, 0, 0, 0, 10'h000, 8'h00);
    @(negedge clk);
    n_checks++;
    if (rr_gnt0 !== 1'b1 || rr_gnt1 !== 1'b0 || rr_mem_addr !== 10'h005 || rr_mem_we !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL single_read_gnt: gnt=%b%b addr=%h we=%b, expected 10 005 0",
               rr_gnt0, rr_gnt1, rr_mem_addr, rr_mem_we);
    end
    sb.push_back('{cyc + 1, 1'b0, 8'h5A});
    next_cycle();
    drive(0, 0, 0, 10'h123, 8'h77, 0, 0, 0, 10'h2AA, 8'h99);
    @(negedge clk);
    n_checks++;
    if (rr_rvalid0 !== 1'b1 || rr_rdata0 !== 8'h5A || rr_rvalid1 !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL single_read_data: rvalid0=%b rdata0=%h rvalid1=%b, expected 1 5a 0",
               rr_rvalid0, rr_rdata0, rr_rvalid1);
    end
    n_checks++;
    if (rr_gnt0 !== 1'b0 || rr_gnt1 !== 1'b0 || rr_mem_we !== 1'b0 ||
        rr_mem_addr !== 10'h123 || rr_mem_wdata !== 8'h77) begin
      n_errors++;
      $display("[TB] FAIL idle_mux: gnt=%b%b we=%b addr=%h wdata=%h, expected 00 0 123 77",
               rr_gnt0, rr_gnt1, rr_mem_we, rr_mem_addr, rr_mem_wdata);
    end
    next_cycle();
  endtask

  task automatic test_round_robin();
    logic [9:0] a0;
    logic [9:0] a1;
    bit         exp_port;
    do_reset();
    a0 = 10'h100;
    a1 = 10'h200;
    for (int k = 0; k < 6; k++) begin
      exp_port = (k % 2 == 1);
      drive(1, 0, 0, a0, 8'h00, 1, 0, 0, a1, 8'h00);
      @(negedge clk);
      n_checks++;
      if (rr_gnt0 !== !exp_port || rr_gnt1 !== exp_port ||
          rr_mem_addr !== (exp_port ? a1 : a0)) begin
        n_errors++;
        $display("[TB] FAIL rr_gnt k=%0d: gnt=%b%b addr=%h, expected %b%b %h",
                 k, rr_gnt0, rr_gnt1, rr_mem_addr, !exp_port, exp_port, exp_port ? a1 : a0);
      end
      sb.push_back('{cyc + 1, exp_port, exp_port ? ref_mem[a1] : ref_mem[a0]});
      next_cycle();
      if (exp_port) a1 = a1 + 10'd1;
      else a0 = a0 + 10'd1;
    end
  endtask

  task automatic test_fixed_pri();
    sb_en = 1'b0;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 0, 10'h050, 8'h00, 1, 0, 0, 10'h060, 8'h00);
      @(negedge clk);
      n_checks++;
      if (fp_gnt0 !== 1'b1 || fp_gnt1 !== 1'b0) begin
        n_errors++;
        $display("[TB] FAIL fp_gnt k=%0d: gnt=%b%b, expected 10", k, fp_gnt0, fp_gnt1);
      end
      if (k > 0) begin
        n_checks++;
        if (fp_rvalid0 !== 1'b1 || fp_rvalid1 !== 1'b0 || fp_rdata0 !== ref_mem[10'h050]) begin
          n_errors++;
          $display("[TB] FAIL fp_rdata k=%0d: rvalid=%b%b rdata0=%h, expected 10 %h",
                   k, fp_rvalid0, fp_rvalid1, fp_rdata0, ref_mem[10'h050]);
        end
      end
      next_cycle();
    end
    drive(0, 0, 0, 10'h050, 8'h00, 1, 0, 0, 10'h060, 8'h00);
    @(negedge clk);
    n_checks++;
    if (fp_gnt0 !== 1'b0 || fp_gnt1 !== 1'b1 || fp_mem_addr !== 10'h060) begin
      n_errors++;
      $display("[TB] FAIL fp_drop_req0: gnt=%b%b addr=%h, expected 01 060", fp_gnt0, fp_gnt1, fp_mem_addr);
    end
    next_cycle();
    do_reset();
    sb_en = 1'b1;
  endtask

  task automatic test_lock();
    do_reset();
    // A lone port 0 read first, so port 1 wins the following tie.
    drive(1, 0, 0, 10'h3FF, 8'h00, 0, 0, 0, 10'h000, 8'h00);
    @(negedge clk);
    n_checks++;
    if (rr_gnt0 !== 1'b1 || rr_gnt1 !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL lock_pre: gnt=%b%b, expected 10", rr_gnt0, rr_gnt1);
    end
    sb.push_back('{cyc + 1, 1'b0, ref_mem[10'h3FF]});
    next_cycle();
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 0, 10'h3FF, 8'h00, 1, 1, 1, 10'h3FF, 8'hA5);
      @(negedge clk);
      n_checks++;
      if (rr_gnt0 !== 1'b0 || rr_gnt1 !== 1'b1 || rr_mem_we !== 1'b1 ||
          rr_mem_addr !== 10'h3FF || rr_mem_wdata !== 8'hA5) begin
        n_errors++;
        $display("[TB] FAIL lock1_hold k=%0d: gnt=%b%b we=%b addr=%h wdata=%h, expected 01 1 3ff a5",
                 k, rr_gnt0, rr_gnt1, rr_mem_we, rr_mem_addr, rr_mem_wdata);
      end
      ref_mem[10'h3FF] = 8'hA5;
      next_cycle();
    end
    // Port 1 lets go; this cycle is still owned by port 1.
    drive(1, 0, 0, 10'h3FF, 8'h00, 0, 0, 0, 10'h000, 8'h00);
    @(negedge clk);
    n_checks++;
    if (rr_gnt0 !== 1'b0 || rr_gnt1 !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL lock1_exit: gnt=%b%b, expected 00", rr_gnt0, rr_gnt1);
    end
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (rr_gnt0 !== 1'b1 || rr_gnt1 !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL lock1_after: gnt=%b%b, expected 10", rr_gnt0, rr_gnt1);
    end
    sb.push_back('{cyc + 1, 1'b0, 8'hA5});
    next_cycle();
  endtask

  task automatic test_write_then_read();
    do_reset();
    drive(1, 1, 0, 10'h010, 8'h11, 0, 0, 0, 10'h000, 8'h00);
    @(negedge clk);
    n_checks++;
    if (rr_gnt0 !== 1'b1 || rr_mem_we !== 1'b1 || rr_mem_addr !== 10'h010 || rr_mem_wdata !== 8'h11) begin
      n_errors++;
      $display("[TB] FAIL wr0: gnt0=%b we=%b addr=%h wdata=%h, expected 1 1 010 11",
               rr_gnt0, rr_mem_we, rr_mem_addr, rr_mem_wdata);
    end
    ref_mem[10'h010] = 8'h11;
    next_cycle();
    drive(0, 0, 0, 10'h000, 8'h00, 1, 0, 0, 10'h010, 8'h00);
    @(negedge clk);
    n_checks++;
    if (rr_gnt1 !== 1'b1 || rr_gnt0 !== 1'b0 || rr_mem_we !== 1'b0 || rr_rvalid0 !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL rd1_after_wr: gnt=%b%b we=%b rvalid0=%b, expected 01 0 0",
               rr_gnt0, rr_gnt1, rr_mem_we, rr_rvalid0);
    end
    sb.push_back('{cyc + 1, 1'b1, 8'h11});
    next_cycle();
    drive(0, 0, 0, 10'h000, 8'h00, 0, 0, 0, 10'h000, 8'h00);
    @(negedge clk);
    n_checks++;
    if (rr_rvalid1 !== 1'b1 || rr_rdata1 !== 8'h11) begin
      n_errors++;
      $display("[TB] FAIL rd1_data: rvalid1=%b rdata1=%h, expected 1 11", rr_rvalid1, rr_rdata1);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    drive(1, 0, 1, 10'h005, 8'h00, 0, 0, 0, 10'h000, 8'h00);
    @(negedge clk);
    n_checks++;
    if (rr_gnt0 !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL mid_gnt0: gnt0=%b, expected 1", rr_gnt0);
    end
    #1;
    nrst = 1'b0;
    #1;
    n_checks++;
    if (rr_gnt0 !== 1'b0 || rr_gnt1 !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL mid_gnt_in_reset: gnt=%b%b, expected 00", rr_gnt0, rr_gnt1);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (rr_rvalid0 !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL mid_rvalid_dropped: rvalid0=%b, expected 0", rr_rvalid0);
    end
    @(posedge clk);
    #1;
    nrst = 1'b1;
    drive(0, 0, 0, 10'h000, 8'h00, 1, 0, 0, 10'h005, 8'h00);
    @(negedge clk);
    n_checks++;
    if (rr_gnt1 !== 1'b1 || rr_gnt0 !== 1'b0 || rr_rvalid0 !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL mid_post_reset: gnt=%b%b rvalid0=%b, expected 01 0",
               rr_gnt0, rr_gnt1, rr_rvalid0);
    end
    sb.push_back('{cyc + 1, 1'b1, ref_mem[10'h005]});
    next_cycle();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
    nrst = 1'b0;
    drive(0, 0, 0, 10'h000, 8'h00, 0, 0, 0, 10'h000, 8'h00);
    @(posedge clk);
    #1;
    $display("[TB] starting mem_arb_2p tests");
    test_reset();
    test_single_read();
    test_round_robin();
    test_fixed_pri();
    test_lock();
    test_write_then_read();
    test_reset_mid_op();
    drive(0, 0, 0, 10'h000, 8'h00, 0, 0, 0, 10'h000, 8'h00);
    repeat (2) next_cycle();
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("[TB] FAIL sb_drain: %0d returns outstanding, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
